// File: rtl/if_id_decode_stage.sv
// -----------------------------------------------------------------------------
// if_id_decode_stage
//
// Second stage of the MIPS pipeline. It holds the IF/ID register (instruction
// and PC+4), the 32-entry register file and the decoder. Jumps and branches
// are resolved in this stage, and the target and select go straight back to
// fetch. Decoded operands and controls are registered into ID/EX.
//
// Parameters
//   SIZE      datapath / instruction / PC width (field slicing assumes 32)
//   REG_ADDR  register index width
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   i_instruction      fetched instruction
//   i_pc_plus4         PC+4 of i_instruction
//   i_stall            hold IF/ID, insert a bubble into ID/EX
//   i_wb_en/addr/data  register-file write port from write-back
//   o_jump_addr/sel    combinational redirect to fetch
//   o_rs_data..o_link  ID/EX register outputs
// -----------------------------------------------------------------------------
module if_id_decode_stage #(
    parameter int unsigned SIZE     = 32,
    parameter int unsigned REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE-1:0]     i_instruction,
    input  logic [SIZE-1:0]     i_pc_plus4,
    input  logic                i_stall,
    input  logic                i_wb_en,
    input  logic [REG_ADDR-1:0] i_wb_addr,
    input  logic [SIZE-1:0]     i_wb_data,
    output logic [SIZE-1:0]     o_jump_addr,
    output logic                o_jump_sel,
    output logic [SIZE-1:0]     o_rs_data,
    output logic [SIZE-1:0]     o_rt_data,
    output logic [SIZE-1:0]     o_imm,
    output logic [REG_ADDR-1:0] o_rs,
    output logic [REG_ADDR-1:0] o_rt,
    output logic [REG_ADDR-1:0] o_rd,
    output logic [4:0]          o_shamt,
    output logic [5:0]          o_funct,
    output logic [SIZE-1:0]     o_pc_plus4,
    output logic                o_reg_write,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_mem_to_reg,
    output logic                o_alu_src,
    output logic                o_reg_dst,
    output logic                o_link
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnJr    = 6'h08;

    // ---------------------------------------------------------------------
    // IF/ID register
    // ---------------------------------------------------------------------
    logic [SIZE-1:0] ifid_instr_q;
    logic [SIZE-1:0] ifid_pc_q;

    // ---------------------------------------------------------------------
    // Instruction fields
    // ---------------------------------------------------------------------
    logic [5:0]          opcode;
    logic [REG_ADDR-1:0] rs_idx;
    logic [REG_ADDR-1:0] rt_idx;
    logic [REG_ADDR-1:0] rd_idx;
    logic [4:0]          shamt;
    logic [5:0]          funct;
    logic [15:0]         imm16;
    logic [25:0]         target26;

    assign opcode   = ifid_instr_q[31:26];
    assign rs_idx   = ifid_instr_q[25:21];
    assign rt_idx   = ifid_instr_q[20:16];
    assign rd_idx   = ifid_instr_q[15:11];
    assign shamt    = ifid_instr_q[10:6];
    assign funct    = ifid_instr_q[5:0];
    assign imm16    = ifid_instr_q[15:0];
    assign target26 = ifid_instr_q[25:0];

    // ---------------------------------------------------------------------
    // Register file with write-through bypass
    // ---------------------------------------------------------------------
    logic [SIZE-1:0] rf_q [NumRegs];
    logic            wb_active;
    logic [SIZE-1:0] rs_data;
    logic [SIZE-1:0] rt_data;

    assign wb_active = i_wb_en && (i_wb_addr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_active) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_idx != '0) begin
            rs_data = (wb_active && (i_wb_addr == rs_idx)) ? i_wb_data : rf_q[rs_idx];
        end
        if (rt_idx != '0) begin
            rt_data = (wb_active && (i_wb_addr == rt_idx)) ? i_wb_data : rf_q[rt_idx];
        end
    end

    // ---------------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------------
    logic dec_reg_write;
    logic dec_mem_read;
    logic dec_mem_write;
    logic dec_mem_to_reg;
    logic dec_alu_src;
    logic dec_reg_dst;
    logic dec_link;
    logic dec_zero_ext;
    logic is_jr;
    logic is_j;
    logic is_beq;
    logic is_bne;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_link       = 1'b0;
        dec_zero_ext   = 1'b0;
        is_jr          = 1'b0;
        is_j           = 1'b0;
        is_beq         = 1'b0;
        is_bne         = 1'b0;
        unique case (opcode)
            OpRtype: begin
                if (funct == FnJr) begin
                    is_jr = 1'b1;
                end else if (ifid_instr_q != '0) begin
                    // The all-zero word is the pipeline NOP (flush/reset filler),
                    // so it carries no controls rather than decoding as sll $0.
                    dec_reg_write = 1'b1;
                    dec_reg_dst   = 1'b1;
                end
            end
            OpAddi, OpAddiu, OpSlti: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OpAndi, OpOri: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_zero_ext  = 1'b1;
            end
            OpLw: begin
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
            end
            OpSw: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OpBeq: is_beq = 1'b1;
            OpBne: is_bne = 1'b1;
            OpJ:   is_j   = 1'b1;
            OpJal: begin
                is_j          = 1'b1;
                dec_reg_write = 1'b1;
                dec_link      = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Immediate and early jump/branch resolution
    // ---------------------------------------------------------------------
    logic [SIZE-1:0] imm_ext;
    logic [SIZE-1:0] imm_sext;
    logic [SIZE-1:0] branch_target;
    logic            jump_taken;
    logic [SIZE-1:0] jump_addr;

    assign imm_sext      = {{(SIZE-16){imm16[15]}}, imm16};
    assign imm_ext       = dec_zero_ext ? {{(SIZE-16){1'b0}}, imm16} : imm_sext;
    assign branch_target = ifid_pc_q + {imm_sext[SIZE-3:0], 2'b00};

    always_comb begin
        jump_taken = 1'b0;
        jump_addr  = '0;
        if (is_j) begin
            jump_taken = 1'b1;
            jump_addr  = {ifid_pc_q[SIZE-1:SIZE-4], target26, 2'b00};
        end else if (is_jr) begin
            jump_taken = 1'b1;
            jump_addr  = rs_data;
        end else if (is_beq || is_bne) begin
            jump_taken = is_beq ? (rs_data == rt_data) : (rs_data != rt_data);
            jump_addr  = branch_target;
        end
    end

    // A stall suppresses the redirect; the held instruction resolves again later.
    assign o_jump_sel  = jump_taken && !i_stall;
    assign o_jump_addr = jump_addr;

    // ---------------------------------------------------------------------
    // IF/ID update: hold on stall, squash on redirect (no delay slot)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else if (i_stall) begin
            ifid_instr_q <= ifid_instr_q;
            ifid_pc_q    <= ifid_pc_q;
        end else if (o_jump_sel) begin
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else begin
            ifid_instr_q <= i_instruction;
            ifid_pc_q    <= i_pc_plus4;
        end
    end

    // ---------------------------------------------------------------------
    // ID/EX register: bubble on stall, otherwise capture the decode
    // ---------------------------------------------------------------------
    logic [SIZE-1:0]     idex_rs_data_q;
    logic [SIZE-1:0]     idex_rt_data_q;
    logic [SIZE-1:0]     idex_imm_q;
    logic [REG_ADDR-1:0] idex_rs_q;
    logic [REG_ADDR-1:0] idex_rt_q;
    logic [REG_ADDR-1:0] idex_rd_q;
    logic [4:0]          idex_shamt_q;
    logic [5:0]          idex_funct_q;
    logic [SIZE-1:0]     idex_pc_q;
    logic [6:0]          idex_ctrl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_rs_q      <= '0;
            idex_rt_q      <= '0;
            idex_rd_q      <= '0;
            idex_shamt_q   <= '0;
            idex_funct_q   <= '0;
            idex_pc_q      <= '0;
            idex_ctrl_q    <= '0;
        end else if (i_stall) begin
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_rs_q      <= '0;
            idex_rt_q      <= '0;
            idex_rd_q      <= '0;
            idex_shamt_q   <= '0;
            idex_funct_q   <= '0;
            idex_pc_q      <= '0;
            idex_ctrl_q    <= '0;
        end else begin
            idex_rs_data_q <= rs_data;
            idex_rt_data_q <= rt_data;
            idex_imm_q     <= imm_ext;
            idex_rs_q      <= rs_idx;
            idex_rt_q      <= rt_idx;
            idex_rd_q      <= dec_link ? {REG_ADDR{1'b1}} : rd_idx;
            idex_shamt_q   <= shamt;
            idex_funct_q   <= funct;
            idex_pc_q      <= ifid_pc_q;
            idex_ctrl_q    <= {dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg,
                               dec_alu_src, dec_reg_dst, dec_link};
        end
    end

    assign o_rs_data    = idex_rs_data_q;
    assign o_rt_data    = idex_rt_data_q;
    assign o_imm        = idex_imm_q;
    assign o_rs         = idex_rs_q;
    assign o_rt         = idex_rt_q;
    assign o_rd         = idex_rd_q;
    assign o_shamt      = idex_shamt_q;
    assign o_funct      = idex_funct_q;
    assign o_pc_plus4   = idex_pc_q;
    assign o_reg_write  = idex_ctrl_q[6];
    assign o_mem_read   = idex_ctrl_q[5];
    assign o_mem_write  = idex_ctrl_q[4];
    assign o_mem_to_reg = idex_ctrl_q[3];
    assign o_alu_src    = idex_ctrl_q[2];
    assign o_reg_dst    = idex_ctrl_q[1];
    assign o_link       = idex_ctrl_q[0];

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Bench for if_id_decode_stage. The driver pushes the expected view of each
// cycle into a queue; the monitor pops and compares on the falling edge.
module tb_if_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc4;
    logic        stall, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic [31:0] o_jump_addr, o_rs_data, o_rt_data, o_imm, o_pc_plus4;
    logic        o_jump_sel;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_funct;
    logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst;
    logic        o_link;

    if_id_decode_stage #(.SIZE(32), .REG_ADDR(5)) dut (
        .clk(clk), .rst(rst),
        .i_instruction(instr), .i_pc_plus4(pc4), .i_stall(stall),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_jump_addr(o_jump_addr), .o_jump_sel(o_jump_sel),
        .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_funct(o_funct),
        .o_pc_plus4(o_pc_plus4),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst),
        .o_link(o_link)
    );

    always #5 clk = ~clk;

    // ctrl order: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, link}
    // mask bits:  [6] ctrl [5] rs_data [4] rt_data [3] imm [2] rd [1] pc_plus4 [0] indices
    typedef struct {
        string       name;
        logic        chk_j;
        logic        chk_ja;
        logic        jsel;
        logic [31:0] jaddr;
        logic [6:0]  mask;
        logic [6:0]  ctrl;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [20:0] idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, req);
        end
    endtask

    task automatic exp_j(input string n, input logic sel, input logic [31:0] addr,
                         input logic chka);
        exp_t e;
        e = '{name: n, chk_j: 1'b1, chk_ja: chka, jsel: sel, jaddr: addr, mask: 7'd0,
              ctrl: 7'd0, rs_d: 32'd0, rt_d: 32'd0, imm: 32'd0, rd: 5'd0, pc: 32'd0,
              idx: 21'd0};
        q.push_back(e);
    endtask

    task automatic exp_x(input string n, input logic [6:0] m, input logic [6:0] c,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] im, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [20:0] idx);
        exp_t e;
        e = '{name: n, chk_j: 1'b0, chk_ja: 1'b0, jsel: 1'b0, jaddr: 32'd0, mask: m,
              ctrl: c, rs_d: rsd, rt_d: rtd, imm: im, rd: rd, pc: pc, idx: idx};
        q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk_j)   chk({e.name, ".jump_sel"}, {31'd0, o_jump_sel}, {31'd0, e.jsel});
            if (e.chk_ja)  chk({e.name, ".jump_addr"}, o_jump_addr, e.jaddr);
            if (e.mask[6]) chk({e.name, ".ctrl"},
                               {25'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                                o_alu_src, o_reg_dst, o_link}, {25'd0, e.ctrl});
            if (e.mask[5]) chk({e.name, ".rs_data"}, o_rs_data, e.rs_d);
            if (e.mask[4]) chk({e.name, ".rt_data"}, o_rt_data, e.rt_d);
            if (e.mask[3]) chk({e.name, ".imm"}, o_imm, e.imm);
            if (e.mask[2]) chk({e.name, ".rd"}, {27'd0, o_rd}, {27'd0, e.rd});
            if (e.mask[1]) chk({e.name, ".pc_plus4"}, o_pc_plus4, e.pc);
            if (e.mask[0]) chk({e.name, ".indices"}, {11'd0, o_rs, o_rt, o_shamt, o_funct},
                               {11'd0, e.idx});
        end
    end

    // One cycle of stimulus, driven 1 time unit after the rising edge.
    task automatic cyc(input logic [31:0] ins, input logic [31:0] p);
        @(posedge clk);
        #1;
        instr = ins;
        pc4   = p;
        stall = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] ADD355 = 32'h00A0_1820;  // add $3,$5,$0
    localparam logic [31:0] ADD400 = 32'h0000_2020;  // add $4,$0,$0
    localparam logic [31:0] BEQ12  = 32'h1022_FFFF;  // beq $1,$2,-1
    localparam logic [31:0] BNE12  = 32'h1422_FFFF;  // bne $1,$2,-1
    localparam logic [31:0] BNE10  = 32'h1420_0003;  // bne $1,$0,+3
    localparam logic [31:0] J100   = 32'h0800_0100;  // j 0x100
    localparam logic [31:0] JAL10  = 32'h0C00_0010;  // jal 0x10
    localparam logic [31:0] JR5    = 32'h00A0_0008;  // jr $5
    localparam logic [6:0]  ALL    = 7'b111_1111;

    logic [31:0] t_ins  [8];
    logic [6:0]  t_ctrl [8];
    logic [31:0] t_imm  [8];

    initial begin
        t_ins[0] = 32'h2001_8000; t_ctrl[0] = 7'b100_0100; t_imm[0] = 32'hFFFF_8000; // addi
        t_ins[1] = 32'h3401_8000; t_ctrl[1] = 7'b100_0100; t_imm[1] = 32'h0000_8000; // ori
        t_ins[2] = 32'h3001_FFFF; t_ctrl[2] = 7'b100_0100; t_imm[2] = 32'h0000_FFFF; // andi
        t_ins[3] = 32'h8C22_0004; t_ctrl[3] = 7'b110_1100; t_imm[3] = 32'h0000_0004; // lw
        t_ins[4] = 32'hAC22_0004; t_ctrl[4] = 7'b001_0100; t_imm[4] = 32'h0000_0004; // sw
        t_ins[5] = 32'hFC00_FFFF; t_ctrl[5] = 7'b000_0000; t_imm[5] = 32'hFFFF_FFFF; // unknown
        t_ins[6] = 32'h2801_8000; t_ctrl[6] = 7'b100_0100; t_imm[6] = 32'hFFFF_8000; // slti
        t_ins[7] = 32'h2401_0001; t_ctrl[7] = 7'b100_0100; t_imm[7] = 32'h0000_0001; // addiu

        rst = 1'b0; instr = NOP; pc4 = 0; stall = 0; wb_en = 0; wb_addr = 0; wb_data = 0;

        // Reset state
        cyc(NOP, 32'h0);
        exp_j("reset", 1'b0, 32'h0, 1'b1);
        exp_x("reset", ALL, 7'd0, 0, 0, 0, 5'd0, 0, 21'd0);
        cyc(NOP, 32'h0);
        rst = 1'b1;

        // NOP stream
        cyc(NOP, 32'h4);
        cyc(NOP, 32'h8);
        cyc(NOP, 32'hC);
        exp_j("nop_stream", 1'b0, 32'h0, 1'b0);
        exp_x("nop_stream", 7'b110_0000, 7'd0, 0, 0, 0, 5'd0, 0, 21'd0);

        // Write-back to $5 bypassed into add $3,$5,$0, then read back from the file
        cyc(ADD355, 32'h10);
        cyc(NOP, 32'h14);
        wb(5'd5, 32'hDEAD_BEEF);
        exp_j("add_no_jump", 1'b0, 32'h0, 1'b0);
        cyc(ADD355, 32'h18);
        exp_x("wb_bypass", ALL, 7'b100_0010, 32'hDEAD_BEEF, 0, 32'h0000_1820, 5'd3, 32'h10,
              {5'd5, 5'd0, 5'd0, 6'h20});
        cyc(NOP, 32'h1C);
        cyc(NOP, 32'h20);
        exp_x("rf_read_5", 7'b110_0010, 7'b100_0010, 32'hDEAD_BEEF, 0, 0, 5'd0, 32'h18, 21'd0);

        // Write to $0 is dropped, and not bypassed either
        cyc(ADD400, 32'h24);
        wb(5'd0, 32'h1234);
        cyc(NOP, 32'h28);
        wb(5'd0, 32'h1234);
        cyc(NOP, 32'h2C);
        exp_x("r0_read", 7'b111_0100, 7'b100_0010, 0, 0, 0, 5'd4, 0, 21'd0);

        // Opcode decode / immediate extension table
        for (int i = 0; i < 10; i++) begin
            cyc((i < 8) ? t_ins[i] : NOP, 32'h100 + 32'(i * 4));
            if (i >= 2) begin
                exp_x($sformatf("decode%0d", i - 2), 7'b100_1010, t_ctrl[i-2], 0, 0,
                      t_imm[i-2], 5'd0, 32'h100 + 32'((i - 2) * 4), 21'd0);
            end
        end

        // Load $1 = $2 = 7
        cyc(NOP, 32'h0);
        wb(5'd1, 32'd7);
        cyc(NOP, 32'h0);
        wb(5'd2, 32'd7);

        // BEQ taken backwards, then the fetched instruction is squashed
        cyc(BEQ12, 32'h40);
        cyc(ADD355, 32'h44);
        exp_j("beq_taken", 1'b1, 32'h3C, 1'b1);
        cyc(NOP, 32'h3C);
        exp_j("after_flush", 1'b0, 32'h0, 1'b0);
        exp_x("beq_idex", 7'b100_1010, 7'd0, 0, 0, 32'hFFFF_FFFF, 5'd0, 32'h40, 21'd0);
        cyc(NOP, 32'h40);
        exp_x("flush_nop", 7'b110_0110, 7'd0, 0, 0, 0, 5'd0, 0, 21'd0);

        // BNE with equal operands falls through; BNE against $0 is taken
        cyc(BNE12, 32'h40);
        cyc(NOP, 32'h44);
        exp_j("bne_not_taken", 1'b0, 32'h0, 1'b0);
        cyc(BNE10, 32'h80);
        cyc(NOP, 32'h84);
        exp_j("bne_taken", 1'b1, 32'h8C, 1'b1);

        // Stall over a held J: bubbles, no redirect, redirect after release
        cyc(J100, 32'h3000_0010);
        cyc(ADD355, 32'h3000_0014);
        stall = 1'b1;
        exp_j("stall1_jsel", 1'b0, 32'h0, 1'b0);
        cyc(ADD355, 32'h3000_0014);
        stall = 1'b1;
        exp_j("stall2_jsel", 1'b0, 32'h0, 1'b0);
        exp_x("stall_bubble", ALL, 7'd0, 0, 0, 0, 5'd0, 0, 21'd0);
        cyc(ADD355, 32'h3000_0014);
        exp_j("j_after_stall", 1'b1, 32'h3000_0400, 1'b1);
        exp_x("stall_bubble2", 7'b110_1010, 7'd0, 0, 0, 0, 5'd0, 0, 21'd0);
        cyc(NOP, 32'h3000_0400);
        exp_j("j_flushed", 1'b0, 32'h0, 1'b0);
        exp_x("j_idex", 7'b100_1010, 7'd0, 0, 0, 32'h0000_0100, 5'd0, 32'h3000_0010, 21'd0);

        // JR to register contents
        cyc(JR5, 32'h50);
        cyc(NOP, 32'h54);
        exp_j("jr_target", 1'b1, 32'hDEAD_BEEF, 1'b1);

        // JAL link, then asynchronous reset in the middle of a cycle
        cyc(JAL10, 32'h20);
        cyc(ADD355, 32'h24);
        exp_j("jal_target", 1'b1, 32'h0000_0040, 1'b1);
        cyc(ADD355, 32'h40);
        exp_x("jal_idex", 7'b100_0110, 7'b100_0001, 0, 0, 0, 5'd31, 32'h20, 21'd0);
        cyc(J100, 32'h44);
        cyc(NOP, 32'h48);
        rst = 1'b0;
        exp_j("mid_reset", 1'b0, 32'h0, 1'b1);
        exp_x("mid_reset", ALL, 7'd0, 0, 0, 0, 5'd0, 0, 21'd0);
        cyc(NOP, 32'h0);
        rst = 1'b1;

        // Register file was cleared by reset
        cyc(ADD355, 32'h60);
        cyc(NOP, 32'h64);
        cyc(NOP, 32'h68);
        exp_x("rf_cleared", 7'b110_0010, 7'b100_0010, 0, 0, 0, 5'd0, 32'h60, 21'd0);

        cyc(NOP, 32'h0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_decode_stage.md
Name: if_id_decode_stage

Overview:
Second pipeline stage of the MIPS core. It latches the fetched instruction and PC+4 into an IF/ID register and holds the 32x32 register file. It decodes control signals and resolves jumps and branches early, driving the jump target and select back to the fetch stage. Decoded operands and controls are registered into an ID/EX register for the execute stage.

Parameters:
SIZE, 32, datapath/instruction/PC width
REG_ADDR, 5, register index width (32 registers)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
i_instruction  in  SIZE  instruction from fetch
i_pc_plus4  in  SIZE  PC+4 of i_instruction
i_stall  in  1  hold IF/ID, bubble into ID/EX
i_wb_en  in  1  register-file write enable from write-back
i_wb_addr  in  REG_ADDR  write-back destination
i_wb_data  in  SIZE  write-back data
o_jump_addr  out  SIZE  target to fetch (feeds fetch jump input)
o_jump_sel  out  1  1 = fetch takes o_jump_addr (feeds fetch mux select)
o_rs_data, o_rt_data  out  SIZE each  registered operands
o_imm  out  SIZE  registered sign-extended immediate
o_rs, o_rt, o_rd  out  REG_ADDR each  registered indices (o_rd=31 for JAL)
o_shamt  out  5  registered shamt
o_funct  out  6  registered funct
o_pc_plus4  out  SIZE  registered PC+4 (JAL link value)
o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_link  out  1 each  registered controls

Behaviour:
- Reset (rst=0, asynchronous): IF/ID instruction=0 (NOP), IF/ID PC=0, all registers 0, all ID/EX outputs 0. o_jump_sel=0 and o_jump_addr=0 follow combinationally from the NOP.
- Timing: instruction present at edge N is in IF/ID after edge N. Jump outputs are combinational from IF/ID during cycle N+1. ID/EX outputs are valid after edge N+1, so latency is 2 edges from fetch output to ID/EX.
- Register file: reads are combinational by rs/rt. Writes occur at the rising edge when i_wb_en=1 and i_wb_addr!=0. Writes to $0 are ignored and $0 always reads 0.
- Write-through bypass: if i_wb_en=1, i_wb_addr!=0 and it equals rs (or rt) in the same cycle, the read returns i_wb_data.
- Decode, supported opcodes:
  - R-type (0x00): reg_write, reg_dst.
  - JR (R-type, funct 0x08): no reg_write, jump to rs_data.
  - ADDI/ADDIU/ANDI/ORI/SLTI (0x08/0x09/0x0C/0x0D/0x0A): reg_write, alu_src.
  - LW (0x23): reg_write, mem_read, mem_to_reg, alu_src.
  - SW (0x2B): mem_write, alu_src.
  - BEQ/BNE (0x04/0x05): no controls.
  - J (0x02): no controls.
  - JAL (0x03): reg_write, link, rd=31.
  - Unknown opcode: all controls 0.
- Immediate: o_imm is imm16 sign-extended for all opcodes except ANDI/ORI, which are zero-extended.
- Jump targets:
  - J/JAL: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - JR: rs_data, including bypass.
  - BEQ/BNE: pc_plus4 + (sext(imm16)<<2), 32-bit wrap-around, taken on rs_data==rt_data (BEQ) or != (BNE).
  - o_jump_sel=1 only when taken and i_stall=0.
- Flush: on an edge where o_jump_sel=1, IF/ID loads NOP (0) and PC 0 instead of the fetched instruction. There is no delay slot. ID/EX still captures the jump instruction itself, so JAL's link write proceeds.
- Stall: on an edge with i_stall=1, IF/ID holds its value and ID/EX loads a bubble (all controls 0, data fields 0). The register file still accepts write-back. Stall overrides jump, and the jump re-evaluates once the stall drops.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.

Test Plan:
- Reset then NOP stream: after rst releases, feed 0x00000000 -> all ID/EX controls 0, o_jump_sel=0, o_rs_data=0.
- Write-back then read: i_wb_en=1, addr=5, data=0xDEADBEEF in the same cycle IF/ID holds `add $3,$5,$0` -> o_rs_data=0xDEADBEEF after the next edge (bypass); a later read of $5 also returns 0xDEADBEEF.
- Write to $0: i_wb_en=1, addr=0, data=0x1234 -> a later read of $0 gives 0.
- BEQ taken: $1=$2=7, BEQ imm=0xFFFF at pc_plus4=0x40 -> o_jump_sel=1, o_jump_addr=0x3C; the next IF/ID is NOP. BNE with the same operands -> o_jump_sel=0.
- Stall: i_stall=1 for 2 cycles while IF/ID holds J 0x100 -> IF/ID is unchanged, ID/EX outputs are bubbles, o_jump_sel=0. After the stall drops: o_jump_sel=1, o_jump_addr={pc_plus4[31:28],0x400}.
- JAL at pc_plus4=0x20 -> ID/EX shows o_reg_write=1, o_link=1, o_rd=31, o_pc_plus4=0x20. Assert rst low mid-cycle afterwards -> all outputs 0 before the next clk edge.
